// File: rtl/banked_mem_responder.sv
// banked_mem_responder: four-bank, word-wide main memory sitting directly
// below one cache. Accepts single-word reads/writes and stalls when the
// addressed bank is busy. It flags malformed requests on err and returns
// read data two cycles after acceptance.
module banked_mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int BANK_T = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);

    localparam int CW = $clog2(BANK_T + 1);
    localparam int MW = $clog2(DEPTH);
    localparam logic [CW-1:0]     BANK_LD   = CW'(BANK_T);
    localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

    // Request decode
    logic [1:0]        bank_s;
    logic [ADDR_W-2:0] word_s;
    logic [MW-1:0]     mem_idx_s;
    logic              req_s;
    logic              range_err_s;
    logic              err_s;
    logic              stall_s;
    logic              accept_s;
    logic [3:0]        busy_s;

    // Bank occupancy counters and read pipeline
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic               p1_vld_q, p1_vld_d;
    logic [DATA_W-1:0]  p1_data_q, p1_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;

    // Storage array; deliberately outside the reset domain so contents survive rst
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_s;

    assign bank_s    = addr[2:1];
    assign word_s    = addr[ADDR_W-1:1];
    assign mem_idx_s = word_s[MW-1:0];
    assign rd_data_s = mem_q[mem_idx_s];

    // Classify the incoming request: illegal, stalled on a busy bank, or accepted
    always_comb begin
        req_s       = wr | rd;
        range_err_s = ({1'b0, word_s} >= DEPTH_LIM);
        err_s       = (wr & rd) | (req_s & addr[0]) | (req_s & range_err_s);
        for (int i = 0; i < 4; i++) begin
            busy_s[i] = (cnt_q[i] != CNT_ZERO);
        end
        stall_s  = req_s & ~err_s & busy_s[bank_s];
        accept_s = req_s & ~err_s & ~stall_s;
    end

    // Next state: reload the accepting bank's counter, others count down to zero
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (accept_s && (bank_s == 2'(i))) begin
                cnt_d[i] = BANK_LD;
            end else if (cnt_q[i] != CNT_ZERO) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = CNT_ZERO;
            end
        end
    end

    // Next state of the two-stage read return path; data_out holds between reads
    always_comb begin
        p1_vld_d   = accept_s & rd;
        p1_data_d  = p1_data_q;
        rd_valid_d = p1_vld_q;
        data_out_d = data_out_q;
        if (accept_s && rd) begin
            p1_data_d = rd_data_s;
        end else begin
            p1_data_d = p1_data_q;
        end
        if (p1_vld_q) begin
            data_out_d = p1_data_q;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Control and pipeline registers; reset drops in-flight reads and frees all banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= {4{CNT_ZERO}};
            p1_vld_q   <= 1'b0;
            p1_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            data_out_q <= {DATA_W{1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            p1_vld_q   <= p1_vld_d;
            p1_data_q  <= p1_data_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    // Array write on an accepted write request
    always_ff @(posedge clk) begin
        if (accept_s && wr) begin
            mem_q[mem_idx_s] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_s;
    assign stall    = stall_s;
    assign err      = err_s;

endmodule
